regfile_banked: RTL and testbench

- Parametrised register file for the datapath.
- Holds a primary (active) bank and a shadow bank; both are readable on every read port.
- Adds over the previous register file:
  - configurable width, depth and read-port count;
  - write-to-read bypass;
  - optional hardwired zero register;
  - bank snapshot, restore and swap;
  - a multi-cycle clear sweep with a busy indication.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_banked.sv | 134 +++++++++++++
 tb/tb_regfile_banked.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_banked.sv
// rtl/regfile_banked.sv - banked register file with write bypass, snapshot/restore/swap and clear sweep
//
// Purpose:
//   Two-bank register file sitting between decode (read addresses) and
//   writeback (write port). The active bank is the architectural state; the
//   shadow bank holds a snapshot that can be restored or swapped in. A
//   multi-cycle sweep clears the active bank one entry per cycle.
//
// Ports:
//   clock      - single clock, all state updates on the rising edge
//   reset      - synchronous, active-low; zeroes both banks and the sweep FSM
//   rd_addr    - NUM_READ packed read addresses, port k at [k*ADDR_BITS +: ADDR_BITS]
//   rd_data    - active-bank read data (with write bypass), port k at [k*WIDTH +: WIDTH]
//   rd_shadow  - shadow-bank read data at the same addresses, never bypassed
//   enc        - write enable
//   wr_addr    - write address
//   wr_data    - write data
//   wr_ack     - write accepted this cycle (combinational)
//   snap       - copy whole active bank into shadow bank
//   restore    - copy whole shadow bank into active bank (snap+restore = swap)
//   clr        - start a clear sweep of the active bank
//   busy       - clear sweep in progress

module regfile_banked #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_READ*ADDR_BITS-1:0] rd_addr,
  output logic [NUM_READ*WIDTH-1:0]     rd_data,
  output logic [NUM_READ*WIDTH-1:0]     rd_shadow,
  input  logic                          enc,
  input  logic [ADDR_BITS-1:0]          wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          wr_ack,
  input  logic                          snap,
  input  logic                          restore,
  input  logic                          clr,
  output logic                          busy
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam bit          ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   cnt;
  logic                   busy_q;

  logic [WIDTH-1:0] active [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];

  logic wr_to_zero;

  assign busy       = busy_q;
  assign wr_to_zero = ZERO_EN && (wr_addr == '0);
  // Restore (and swap) overwrite the whole active bank, so a coincident
  // write would be lost anyway; refusing it keeps wr_ack honest.
  assign wr_ack     = enc && !busy_q && !restore && !wr_to_zero;

  // Read ports: combinational from both banks. Only the active bank sees
  // the write bypass so that decode can consume a value in its writeback
  // cycle; the shadow is a pure snapshot.
  genvar k;
  for (k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_BITS-1:0] ra;
    logic                 zero_hit;

    assign ra       = rd_addr[k*ADDR_BITS +: ADDR_BITS];
    assign zero_hit = ZERO_EN && (ra == '0);

    assign rd_data[k*WIDTH +: WIDTH] =
      zero_hit                   ? '0      :
      (wr_ack && wr_addr == ra)  ? wr_data :
                                   active[ra];

    assign rd_shadow[k*WIDTH +: WIDTH] = zero_hit ? '0 : shadow[ra];
  end

  // State update. In SWEEP every other request is ignored. In IDLE, clr
  // only arms the sweep; snap/restore/write in the same cycle still take
  // effect. Non-blocking copies use pre-edge values, so snap+restore
  // together is a swap for free. Entry 0 never becomes nonzero under
  // ZERO_REG because neither bank can receive a nonzero value there.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          active[cnt] <= '0;
          if (cnt == {ADDR_BITS{1'b1}}) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          if (clr) begin
            state  <= SWEEP;
            cnt    <= '0;
            busy_q <= 1'b1;
          end

          for (int i = 0; i < DEPTH; i++) begin
            if (restore) active[i] <= shadow[i];
            if (snap)    shadow[i] <= active[i];
          end

          // wr_ack is already low under restore, so this never races
          // the bank copy above.
          if (wr_ack) active[wr_addr] <= wr_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_banked.sv
// tb/tb_regfile_banked.sv - directed self-checking bench for regfile_banked

module tb_regfile_banked;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 5;
  localparam int NUM_READ  = 2;

  logic                          clock;
  logic                          reset;
  logic [NUM_READ*ADDR_BITS-1:0] rd_addr;
  logic [NUM_READ*WIDTH-1:0]     rd_data;
  logic [NUM_READ*WIDTH-1:0]     rd_shadow;
  logic                          enc;
  logic [ADDR_BITS-1:0]          wr_addr;
  logic [WIDTH-1:0]              wr_data;
  logic                          wr_ack;
  logic                          snap;
  logic                          restore;
  logic                          clr;
  logic                          busy;

  int checks;
  int errors;

  regfile_banked #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .NUM_READ (NUM_READ),
    .ZERO_REG (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_shadow(rd_shadow),
    .enc      (enc),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .snap     (snap),
    .restore  (restore),
    .clr      (clr),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_BITS-1:0] a0, input logic [ADDR_BITS-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_BITS-1:0] a, input logic [31:0] d);
    enc     = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    enc     = 1'b0;
  endtask

  int cycles;

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    rd_addr = '0;
    enc     = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    snap    = 1'b0;
    restore = 1'b0;
    clr     = 1'b0;

    // Reset: everything reads zero.
    step();
    reset = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_wr_ack_idle", {31'd0, wr_ack}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], 5'(31 - a));
      chk("reset_rd0", rd_data[31:0], 32'd0);
      chk("reset_rd1", rd_data[63:32], 32'd0);
      chk("reset_sh0", rd_shadow[31:0], 32'd0);
      chk("reset_sh1", rd_shadow[63:32], 32'd0);
    end

    // Write with same-cycle bypass.
    enc = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    set_rd(5'd5, 5'd6);
    chk("bypass_rd0", rd_data[31:0], 32'hDEADBEEF);
    chk("bypass_rd1_other", rd_data[63:32], 32'd0);
    chk("bypass_shadow", rd_shadow[31:0], 32'd0);
    chk("bypass_wr_ack", {31'd0, wr_ack}, 32'd1);
    step();
    enc = 1'b0;
    #1;
    chk("stored_rd0", rd_data[31:0], 32'hDEADBEEF);
    set_rd(5'd6, 5'd5);
    chk("stored_rd1", rd_data[63:32], 32'hDEADBEEF);

    // Zero register refuses writes.
    enc = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    set_rd(5'd0, 5'd0);
    chk("zero_wr_ack", {31'd0, wr_ack}, 32'd0);
    chk("zero_bypass", rd_data[31:0], 32'd0);
    step();
    enc = 1'b0;
    #1;
    chk("zero_after", rd_data[31:0], 32'd0);

    // Snap then overwrite: shadow keeps the old value.
    write_reg(5'd3, 32'd7);
    snap = 1'b1; step(); snap = 1'b0;
    write_reg(5'd3, 32'd9);
    set_rd(5'd3, 5'd5);
    chk("snap_rd", rd_data[31:0], 32'd9);
    chk("snap_sh", rd_shadow[31:0], 32'd7);
    chk("snap_sh_r5", rd_shadow[63:32], 32'hDEADBEEF);

    // Restore drops the coincident write.
    restore = 1'b1; enc = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFF;
    set_rd(5'd3, 5'd4);
    chk("restore_wr_ack", {31'd0, wr_ack}, 32'd0);
    chk("restore_no_bypass", rd_data[63:32], 32'd0);
    step();
    restore = 1'b0; enc = 1'b0;
    #1;
    chk("restore_r3", rd_data[31:0], 32'd7);
    chk("restore_r4", rd_data[63:32], 32'd0);

    // Swap: active r2=1, shadow r2=2.
    write_reg(5'd2, 32'd2);
    snap = 1'b1; step(); snap = 1'b0;
    write_reg(5'd2, 32'd1);
    set_rd(5'd2, 5'd2);
    chk("preswap_rd", rd_data[31:0], 32'd1);
    chk("preswap_sh", rd_shadow[31:0], 32'd2);
    snap = 1'b1; restore = 1'b1; step(); snap = 1'b0; restore = 1'b0;
    #1;
    chk("swap_rd", rd_data[31:0], 32'd2);
    chk("swap_sh", rd_shadow[31:0], 32'd1);

    // Clear sweep: fill, snap, sweep, then check both banks.
    for (int a = 1; a < 32; a++) write_reg(a[4:0], 32'hA5A5A5A5);
    snap = 1'b1; step(); snap = 1'b0;
    chk("pre_clr_busy", {31'd0, busy}, 32'd0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_busy_rise", {31'd0, busy}, 32'd1);
    enc = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    cycles = 0;
    while (busy && cycles < 40) begin
      if (cycles < 3 || cycles == 20) chk("busy_wr_ack", {31'd0, wr_ack}, 32'd0);
      cycles++;
      step();
    end
    enc = 1'b0;
    chk("busy_cycles", cycles, 32'd32);
    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], a[4:0]);
      chk("sweep_active", rd_data[31:0], 32'd0);
      chk("sweep_shadow", rd_shadow[63:32], (a == 0) ? 32'd0 : 32'hA5A5A5A5);
    end
    step();
    chk("no_resweep", {31'd0, busy}, 32'd0);

    // Reset in the middle of a sweep.
    write_reg(5'd20, 32'h77);
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_sweep_busy", {31'd0, busy}, 32'd1);
    set_rd(5'd20, 5'd20);
    chk("mid_sweep_r20", rd_data[31:0], 32'h77);
    reset = 1'b0; step(); reset = 1'b1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      set_rd(a[4:0], a[4:0]);
      chk("rst_mid_active", rd_data[63:32], 32'd0);
      chk("rst_mid_shadow", rd_shadow[31:0], 32'd0);
    end
    enc = 1'b1; wr_addr = 5'd3; wr_data = 32'h3;
    #1;
    chk("rst_mid_wr_ack", {31'd0, wr_ack}, 32'd1);
    step();
    enc = 1'b0;
    chk("rst_mid_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
